// File: rtl/alu_uart_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_uart_sequencer_if
// Bundles the UART RX/TX and ALU signals seen by the ALU/UART sequencer.
//   master : sequencer side (drives operands, opcode, TX byte/start, busy, err)
//   slave  : environment side (UART RX, UART TX done, combinational ALU result)
// Signals:
//   i_rx_data / i_rx_valid   received byte and its one-cycle valid pulse
//   i_alu_result             combinational ALU output
//   i_tx_done                one-cycle pulse when TX finished a byte
//   o_alu_data_A/B, o_alu_op operand and opcode registers feeding the ALU
//   o_tx_data / o_tx_start   result byte and its one-cycle send request
//   o_busy / o_err           busy flag and error pulse
// -----------------------------------------------------------------------------
interface alu_uart_sequencer_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) ();
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_alu_data_A;
  logic [NB_DATA-1:0] o_alu_data_B;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_err;

  modport master (
    input  i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
    output o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data, o_tx_start,
           o_busy, o_err
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
    input  o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data, o_tx_start,
           o_busy, o_err
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// -----------------------------------------------------------------------------
// alu_uart_sequencer
// Collects operand A, operand B and opcode as three consecutive UART bytes,
// presents them to the combinational ALU, captures the result and hands it
// to the UART transmitter with a start/done handshake.
// Ports:
//   i_clk    system clock (rising edge)
//   i_reset  synchronous active-high reset
//   bus      alu_uart_sequencer_if.master (RX byte, ALU, TX handshake, flags)
// Optional feature: define ALU_SEQ_TIMEOUT_EN to abandon a frame whose next
// byte does not arrive within TIMEOUT cycles (in WAIT_B / WAIT_OP).
// -----------------------------------------------------------------------------
module alu_uart_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  alu_uart_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [NB_DATA-1:0] data_a_r, data_b_r, tx_data_r;
  logic [NB_OP-1:0]   op_r;
  logic               tx_start_r, busy_r, err_r;
  logic               drop_s, expire_s, timeout_hit_s;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_r;

  // Expiry fires on the idle cycle that would bring the count up to TIMEOUT.
  assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  // Inter-byte idle counter: counts only idle cycles inside a partial frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (((state_r == WAIT_B) || (state_r == WAIT_OP)) &&
                 !bus.i_rx_valid && !timeout_hit_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state logic plus drop/expiry detection.
  always_comb begin
    state_nxt_s = state_r;
    drop_s      = 1'b0;
    expire_s    = 1'b0;
    case (state_r)
      WAIT_A: begin
        if (bus.i_rx_valid) state_nxt_s = WAIT_B;
        else                state_nxt_s = WAIT_A;
      end
      WAIT_B: begin
        if (bus.i_rx_valid) begin
          state_nxt_s = WAIT_OP;
        end else if (timeout_hit_s) begin
          state_nxt_s = WAIT_A;
          expire_s    = 1'b1;
        end else begin
          state_nxt_s = WAIT_B;
        end
      end
      WAIT_OP: begin
        if (bus.i_rx_valid) begin
          state_nxt_s = EXEC;
        end else if (timeout_hit_s) begin
          state_nxt_s = WAIT_A;
          expire_s    = 1'b1;
        end else begin
          state_nxt_s = WAIT_OP;
        end
      end
      EXEC: begin
        state_nxt_s = SEND;
        drop_s      = bus.i_rx_valid;
      end
      SEND: begin
        state_nxt_s = WAIT_TX;
        drop_s      = bus.i_rx_valid;
      end
      WAIT_TX: begin
        drop_s = bus.i_rx_valid;
        if (bus.i_tx_done) state_nxt_s = WAIT_A;
        else               state_nxt_s = WAIT_TX;
      end
      default: begin
        state_nxt_s = WAIT_A;
      end
    endcase
  end

  // State and output registers; start is raised for the SEND cycle only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= WAIT_A;
      data_a_r   <= {NB_DATA{1'b0}};
      data_b_r   <= {NB_DATA{1'b0}};
      op_r       <= {NB_OP{1'b0}};
      tx_data_r  <= {NB_DATA{1'b0}};
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == WAIT_A) && bus.i_rx_valid) data_a_r <= bus.i_rx_data;
      if ((state_r == WAIT_B) && bus.i_rx_valid) data_b_r <= bus.i_rx_data;
      if ((state_r == WAIT_OP) && bus.i_rx_valid) op_r <= bus.i_rx_data[NB_OP-1:0];
      if (state_r == EXEC) tx_data_r <= bus.i_alu_result;
      tx_start_r <= (state_r == EXEC);
      busy_r     <= (state_nxt_s == EXEC) || (state_nxt_s == SEND) ||
                    (state_nxt_s == WAIT_TX);
      err_r      <= drop_s || expire_s;
    end
  end

  assign bus.o_alu_data_A = data_a_r;
  assign bus.o_alu_data_B = data_b_r;
  assign bus.o_alu_op     = op_r;
  assign bus.o_tx_data    = tx_data_r;
  assign bus.o_tx_start   = tx_start_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_err        = err_r;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_sequencer
// Directed bench for alu_uart_sequencer. The bench plays the ALU (a small
// opcode table), drives RX bytes and TX done pulses, and keeps a frame-level
// model of what the sequencer outputs must be. Every cycle after reset the
// outputs are compared with the model; a few literal expectations pin the
// model against hand-computed values.
// -----------------------------------------------------------------------------
module tb_alu_uart_sequencer;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  alu_uart_sequencer_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_sequencer #(.NB_DATA(8), .NB_OP(6), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   alu_fn = a + b;
      6'h22:   alu_fn = a - b;
      6'h24:   alu_fn = a & b;
      6'h25:   alu_fn = a | b;
      6'h26:   alu_fn = a ^ b;
      6'h27:   alu_fn = ~(a | b);
      6'h02:   alu_fn = a >> b[2:0];
      default: alu_fn = 8'h00;
    endcase
  endfunction

  // Bench acts as the combinational ALU.
  assign bus.i_alu_result = alu_fn(bus.o_alu_data_A, bus.o_alu_data_B, bus.o_alu_op);

  // ---------------- behavioural model ----------------
  int         bytes_in_frame = 0;  // bytes already taken for the current frame
  int         after_op = 0;        // cycles since opcode: 0 none, 1 exec, 2 send, 3 waiting done
  int         idle_cnt = 0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_tx = 8'h00;
  logic [5:0] m_op = 6'h00;
  logic       m_start = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  bit         model_live = 1'b0;

  task automatic model_step();
    if (rst) begin
      bytes_in_frame = 0; after_op = 0; idle_cnt = 0;
      m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
      m_start = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      model_live = 1'b1;
    end else begin
      m_err   = 1'b0;
      m_start = 1'b0;
      if (after_op != 0) begin
        if (bus.i_rx_valid) m_err = 1'b1;
        if (after_op == 1) begin
          m_tx = alu_fn(m_a, m_b, m_op);
          m_start = 1'b1;
          after_op = 2;
        end else if (after_op == 2) begin
          after_op = 3;
        end else if (bus.i_tx_done) begin
          after_op = 0;
        end
      end else if (bus.i_rx_valid) begin
        if (bytes_in_frame == 0) m_a = bus.i_rx_data;
        else if (bytes_in_frame == 1) m_b = bus.i_rx_data;
        else m_op = bus.i_rx_data[5:0];
        idle_cnt = 0;
        if (bytes_in_frame == 2) begin
          bytes_in_frame = 0;
          after_op = 1;
        end else begin
          bytes_in_frame++;
        end
      end else if (bytes_in_frame != 0) begin
`ifdef ALU_SEQ_TIMEOUT_EN
        idle_cnt++;
        if (idle_cnt == TIMEOUT) begin
          bytes_in_frame = 0;
          idle_cnt = 0;
          m_err = 1'b1;
        end
`endif
      end
      m_busy = (after_op != 0);
    end
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("alu_data_A", 32'(bus.o_alu_data_A), 32'(m_a));
      check("alu_data_B", 32'(bus.o_alu_data_B), 32'(m_b));
      check("alu_op",     32'(bus.o_alu_op),     32'(m_op));
      check("tx_data",    32'(bus.o_tx_data),    32'(m_tx));
      check("tx_start",   32'(bus.o_tx_start),   32'(m_start));
      check("busy",       32'(bus.o_busy),       32'(m_busy));
      check("err",        32'(bus.o_err),        32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_done  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    check("reset_tx_data", 32'(bus.o_tx_data), 32'd0);

    // Frame 1: 5 + 3 via ADD.
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    check("f1_op", 32'(bus.o_alu_op), 32'h20);
    check("f1_start_not_yet", 32'(bus.o_tx_start), 32'd0);
    tick();
    check("f1_start", 32'(bus.o_tx_start), 32'd1);
    check("f1_tx_data", 32'(bus.o_tx_data), 32'h08);
    tick();
    check("f1_start_one_cycle", 32'(bus.o_tx_start), 32'd0);
    tick();
    pulse_done();
    check("f1_idle_busy", 32'(bus.o_busy), 32'd0);

    // Spurious done in WAIT_A and WAIT_B, then frame 2 with high opcode bits.
    pulse_done();
    send_byte(8'h0F);
    pulse_done();
    check("spurious_done_A", 32'(bus.o_alu_data_A), 32'h0F);
    send_byte(8'hF0);
    send_byte(8'hE5);
    check("f2_op", 32'(bus.o_alu_op), 32'h25);
    tick();
    check("f2_tx_data", 32'(bus.o_tx_data), 32'hFF);
    tick();
    send_byte(8'hAA);  // dropped in WAIT_TX
    check("drop_err", 32'(bus.o_err), 32'd1);
    check("drop_A_kept", 32'(bus.o_alu_data_A), 32'h0F);
    check("drop_tx_kept", 32'(bus.o_tx_data), 32'hFF);
    tick();
    check("drop_err_one_cycle", 32'(bus.o_err), 32'd0);
    pulse_done();
    check("f2_idle_busy", 32'(bus.o_busy), 32'd0);

    // Reset while waiting for the opcode.
    send_byte(8'h07);
    send_byte(8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_A", 32'(bus.o_alu_data_A), 32'd0);
    check("rst_B", 32'(bus.o_alu_data_B), 32'd0);
    check("rst_tx", 32'(bus.o_tx_data), 32'd0);
    send_byte(8'h20);  // now operand A
    check("after_rst_A", 32'(bus.o_alu_data_A), 32'h20);
    tick();
    check("after_rst_no_start", 32'(bus.o_tx_start), 32'd0);
    send_byte(8'h05);
    send_byte(8'h22);
    tick();
    check("f3_tx_data", 32'(bus.o_tx_data), 32'h1B);
    tick();
    pulse_done();

`ifdef ALU_SEQ_TIMEOUT_EN
    // Timeout after 16 idle cycles.
    send_byte(8'h11);
    repeat (TIMEOUT - 1) tick();
    check("to_not_yet", 32'(bus.o_err), 32'd0);
    tick();
    check("to_err", 32'(bus.o_err), 32'd1);
    send_byte(8'h22);
    send_byte(8'h01);
    send_byte(8'h22);
    tick();
    check("to_tx_data", 32'(bus.o_tx_data), 32'h21);
    tick();
    pulse_done();
    // Byte arriving on the expiry cycle is accepted.
    send_byte(8'h33);
    repeat (TIMEOUT - 1) tick();
    send_byte(8'h44);
    check("expiry_no_err", 32'(bus.o_err), 32'd0);
    check("expiry_B", 32'(bus.o_alu_data_B), 32'h44);
    send_byte(8'h20);
    tick();
    check("expiry_tx", 32'(bus.o_tx_data), 32'h77);
    tick();
    pulse_done();
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
